// File: rtl/cpl_pkg.sv
// Shared types and default widths for the completion operation demux slice.
// Record types describe the default configuration; parameterised modules derive their own widths.
package cpl_pkg;

   localparam int unsigned CPL_SELECT_WIDTH      = 2;
   localparam int unsigned CPL_QUEUE_INDEX_WIDTH = 13;
   localparam int unsigned CPL_REQ_TAG_WIDTH     = 7;
   localparam int unsigned CPL_SIZE              = 32;
   localparam int unsigned CPL_DATA_WIDTH        = CPL_SIZE * 8;

   typedef struct packed {
      logic [CPL_REQ_TAG_WIDTH-1:0] tag;
      logic                         full;
      logic                         error;
   } cpl_status_t;

   typedef struct packed {
      logic [CPL_QUEUE_INDEX_WIDTH-1:0] queue;
      logic [CPL_REQ_TAG_WIDTH-1:0]     tag;
      logic [CPL_DATA_WIDTH-1:0]        data;
   } cpl_req_t;

   // Packed status record width for an arbitrary tag width: {tag, full, error}.
   function automatic int unsigned cpl_status_width(input int unsigned tag_w);
      return tag_w + 2;
   endfunction

endpackage

// File: rtl/cpl_status_fifo.sv
// Small synchronous FIFO holding returned completion statuses for one downstream port.
// Pointers carry one extra wrap bit so full and empty are distinguished without a counter.
module cpl_status_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_empty,
   output logic             o_full
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
   end

endmodule

// File: rtl/cpl_op_demux.sv
// Steers completion requests to PORTS write modules by select field and merges their
// status returns (plus invalid-select errors) into one round-robin arbitrated status stream.
module cpl_op_demux
   import cpl_pkg::*;
#(
   parameter int unsigned PORTS             = 2,
   parameter int unsigned SELECT_WIDTH      = CPL_SELECT_WIDTH,
   parameter int unsigned QUEUE_INDEX_WIDTH = CPL_QUEUE_INDEX_WIDTH,
   parameter int unsigned REQ_TAG_WIDTH     = CPL_REQ_TAG_WIDTH,
   parameter int unsigned CPL_SIZE          = cpl_pkg::CPL_SIZE,
   parameter int unsigned STATUS_FIFO_DEPTH = 4
) (
   input  logic                                 clk,
   input  logic                                 rst_n,

   input  logic [SELECT_WIDTH-1:0]              s_axis_req_sel,
   input  logic [QUEUE_INDEX_WIDTH-1:0]         s_axis_req_queue,
   input  logic [REQ_TAG_WIDTH-1:0]             s_axis_req_tag,
   input  logic [CPL_SIZE*8-1:0]                s_axis_req_data,
   input  logic                                 s_axis_req_valid,
   output logic                                 s_axis_req_ready,

   output logic [PORTS*QUEUE_INDEX_WIDTH-1:0]   m_axis_req_queue,
   output logic [PORTS*REQ_TAG_WIDTH-1:0]       m_axis_req_tag,
   output logic [PORTS*CPL_SIZE*8-1:0]          m_axis_req_data,
   output logic [PORTS-1:0]                     m_axis_req_valid,
   input  logic [PORTS-1:0]                     m_axis_req_ready,

   input  logic [PORTS*REQ_TAG_WIDTH-1:0]       s_axis_req_status_tag,
   input  logic [PORTS-1:0]                     s_axis_req_status_full,
   input  logic [PORTS-1:0]                     s_axis_req_status_error,
   input  logic [PORTS-1:0]                     s_axis_req_status_valid,

   output logic [REQ_TAG_WIDTH-1:0]             m_axis_req_status_tag,
   output logic                                 m_axis_req_status_full,
   output logic                                 m_axis_req_status_error,
   output logic                                 m_axis_req_status_valid,

   output logic                                 status_unexpected
);

   localparam int unsigned DATA_WIDTH = CPL_SIZE * 8;
   localparam int unsigned SRC        = PORTS + 1;
   localparam int unsigned PTR_W      = $clog2(SRC);
   localparam int unsigned CNT_W      = $clog2(STATUS_FIFO_DEPTH) + 1;
   localparam int unsigned STAT_W     = cpl_status_width(REQ_TAG_WIDTH);
   localparam logic [CNT_W-1:0] OUTST_MAX = CNT_W'(STATUS_FIFO_DEPTH);

   // Request path state
   logic [PORTS-1:0]                         r_req_valid;
   logic [PORTS-1:0][QUEUE_INDEX_WIDTH-1:0]  r_req_queue;
   logic [PORTS-1:0][REQ_TAG_WIDTH-1:0]      r_req_tag;
   logic [PORTS-1:0][DATA_WIDTH-1:0]         r_req_data;
   logic [PORTS-1:0][CNT_W-1:0]              r_outst;

   // Error slot, arbiter and status output state
   logic                                     r_err_valid;
   logic [REQ_TAG_WIDTH-1:0]                 r_err_tag;
   logic [PTR_W-1:0]                         r_rr_ptr;
   logic                                     r_stat_valid;
   logic [REQ_TAG_WIDTH-1:0]                 r_stat_tag;
   logic                                     r_stat_full;
   logic                                     r_stat_error;
   logic                                     r_unexpected;

   logic [PORTS-1:0]                         w_sel_hit;
   logic [PORTS-1:0]                         w_port_open;
   logic                                     w_sel_ok;
   logic                                     w_err_free;
   logic                                     w_ready;
   logic [PORTS-1:0]                         w_accept;
   logic                                     w_err_accept;

   logic [PORTS-1:0]                         w_fifo_push;
   logic [PORTS-1:0]                         w_fifo_pop;
   logic [PORTS-1:0]                         w_fifo_empty;
   logic [PORTS-1:0]                         w_fifo_full;
   logic [PORTS-1:0][STAT_W-1:0]             w_fifo_wdata;
   logic [PORTS-1:0][STAT_W-1:0]             w_fifo_rdata;

   logic [SRC-1:0]                           w_src_req;
   logic [SRC-1:0]                           w_req_rot;
   logic                                     w_grant_any;
   logic [PTR_W-1:0]                         w_grant_idx;
   logic [PTR_W:0]                           w_sum;
   logic                                     w_err_pop;
   logic [STAT_W-1:0]                        w_grant_stat;
   logic [PTR_W-1:0]                         w_ptr_next;

   // ---------------------------------------------------------------- request path
   always_comb begin
      w_sel_hit   = '0;
      w_port_open = '0;
      for (int i = 0; i < PORTS; i++) begin
         w_sel_hit[i]   = (s_axis_req_sel == SELECT_WIDTH'(i));
         w_port_open[i] = (!r_req_valid[i] || m_axis_req_ready[i]) && (r_outst[i] < OUTST_MAX);
      end
   end

   assign w_sel_ok         = |w_sel_hit;
   assign w_err_free       = !r_err_valid || w_err_pop;
   // Ready is forced low while reset is held so nothing is taken during reset.
   assign w_ready          = rst_n && (w_sel_ok ? |(w_sel_hit & w_port_open) : w_err_free);
   assign w_accept         = (s_axis_req_valid && w_ready) ? w_sel_hit : '0;
   assign w_err_accept     = s_axis_req_valid && w_ready && !w_sel_ok;
   assign s_axis_req_ready = w_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req_valid <= '0;
         r_req_queue <= '0;
         r_req_tag   <= '0;
         r_req_data  <= '0;
      end else begin
         for (int i = 0; i < PORTS; i++) begin
            if (w_accept[i]) begin
               r_req_valid[i] <= 1'b1;
               r_req_queue[i] <= s_axis_req_queue;
               r_req_tag[i]   <= s_axis_req_tag;
               r_req_data[i]  <= s_axis_req_data;
            end else if (m_axis_req_ready[i]) begin
               r_req_valid[i] <= 1'b0;
            end
         end
      end
   end

   assign m_axis_req_valid = r_req_valid;
   assign m_axis_req_queue = r_req_queue;
   assign m_axis_req_tag   = r_req_tag;
   assign m_axis_req_data  = r_req_data;

   // Outstanding counters bound each FIFO's occupancy, so status pushes never need backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_outst      <= '0;
         r_unexpected <= 1'b0;
      end else begin
         for (int i = 0; i < PORTS; i++) begin
            if (w_accept[i] && !w_fifo_pop[i]) begin
               r_outst[i] <= r_outst[i] + CNT_W'(1);
            end else if (!w_accept[i] && w_fifo_pop[i]) begin
               r_outst[i] <= r_outst[i] - CNT_W'(1);
            end
            if (s_axis_req_status_valid[i] && (r_outst[i] == '0)) r_unexpected <= 1'b1;
         end
      end
   end

   assign status_unexpected = r_unexpected;

   // ---------------------------------------------------------------- status capture
   for (genvar g = 0; g < PORTS; g++) begin : g_fifo
      assign w_fifo_wdata[g] = {s_axis_req_status_tag[g*REQ_TAG_WIDTH +: REQ_TAG_WIDTH],
                                s_axis_req_status_full[g], s_axis_req_status_error[g]};
      assign w_fifo_push[g]  = s_axis_req_status_valid[g] && (r_outst[g] != '0) &&
                               !w_fifo_full[g];

      cpl_status_fifo #(
         .DEPTH (STATUS_FIFO_DEPTH),
         .WIDTH (STAT_W)
      ) u_fifo (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_push  (w_fifo_push[g]),
         .i_wdata (w_fifo_wdata[g]),
         .i_pop   (w_fifo_pop[g]),
         .o_rdata (w_fifo_rdata[g]),
         .o_empty (w_fifo_empty[g]),
         .o_full  (w_fifo_full[g])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_valid <= 1'b0;
         r_err_tag   <= '0;
      end else if (w_err_accept) begin
         r_err_valid <= 1'b1;
         r_err_tag   <= s_axis_req_tag;
      end else if (w_err_pop) begin
         r_err_valid <= 1'b0;
      end
   end

   // ---------------------------------------------------------------- status merge
   // Rotating the request vector by the pointer turns round-robin into first-set-bit search.
   always_comb begin
      w_src_req    = {r_err_valid, ~w_fifo_empty};
      w_req_rot    = SRC'({w_src_req, w_src_req} >> r_rr_ptr);
      w_grant_any  = 1'b0;
      w_grant_idx  = '0;
      w_sum        = '0;
      for (int unsigned k = 0; k < SRC; k++) begin
         if (!w_grant_any && w_req_rot[k]) begin
            w_grant_any = 1'b1;
            w_sum       = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
            if (w_sum >= (PTR_W+1)'(SRC)) w_sum = w_sum - (PTR_W+1)'(SRC);
            w_grant_idx = w_sum[PTR_W-1:0];
         end
      end
   end

   always_comb begin
      w_fifo_pop   = '0;
      w_err_pop    = w_grant_any && (w_grant_idx == PTR_W'(PORTS));
      w_grant_stat = {r_err_tag, 1'b0, 1'b1};
      for (int j = 0; j < PORTS; j++) begin
         w_fifo_pop[j] = w_grant_any && (w_grant_idx == PTR_W'(j));
         if (w_fifo_pop[j]) w_grant_stat = w_fifo_rdata[j];
      end
      w_ptr_next = (w_grant_idx == PTR_W'(PORTS)) ? '0 : w_grant_idx + PTR_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr     <= '0;
         r_stat_valid <= 1'b0;
         r_stat_tag   <= '0;
         r_stat_full  <= 1'b0;
         r_stat_error <= 1'b0;
      end else begin
         r_stat_valid <= w_grant_any;
         if (w_grant_any) begin
            r_rr_ptr     <= w_ptr_next;
            r_stat_tag   <= w_grant_stat[STAT_W-1:2];
            r_stat_full  <= w_grant_stat[1];
            r_stat_error <= w_grant_stat[0];
         end
      end
   end

   assign m_axis_req_status_valid = r_stat_valid;
   assign m_axis_req_status_tag   = r_stat_tag;
   assign m_axis_req_status_full  = r_stat_full;
   assign m_axis_req_status_error = r_stat_error;

endmodule

// File: tb/tb_cpl_op_demux.sv
// Directed bench for cpl_op_demux: routing, invalid select, backpressure/outstanding limit,
// simultaneous status merge, FIFO wrap and mid-operation reset, with hand-computed expectations.
module tb_cpl_op_demux;
   import cpl_pkg::*;

   localparam int unsigned P  = 2;
   localparam int unsigned SW = 2;
   localparam int unsigned QW = 13;
   localparam int unsigned TW = 7;
   localparam int unsigned DW = 256;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic [SW-1:0]     s_axis_req_sel;
   logic [QW-1:0]     s_axis_req_queue;
   logic [TW-1:0]     s_axis_req_tag;
   logic [DW-1:0]     s_axis_req_data;
   logic              s_axis_req_valid;
   logic              s_axis_req_ready;
   logic [P*QW-1:0]   m_axis_req_queue;
   logic [P*TW-1:0]   m_axis_req_tag;
   logic [P*DW-1:0]   m_axis_req_data;
   logic [P-1:0]      m_axis_req_valid;
   logic [P-1:0]      m_axis_req_ready;
   logic [P*TW-1:0]   s_axis_req_status_tag;
   logic [P-1:0]      s_axis_req_status_full;
   logic [P-1:0]      s_axis_req_status_error;
   logic [P-1:0]      s_axis_req_status_valid;
   logic [TW-1:0]     m_axis_req_status_tag;
   logic              m_axis_req_status_full;
   logic              m_axis_req_status_error;
   logic              m_axis_req_status_valid;
   logic              status_unexpected;

   int          n_checks = 0;
   int          n_fail   = 0;
   cpl_status_t exp_q[$];
   cpl_status_t mon_got;
   logic [DW-1:0] data1;

   cpl_op_demux #(
      .PORTS             (P),
      .SELECT_WIDTH      (SW),
      .QUEUE_INDEX_WIDTH (QW),
      .REQ_TAG_WIDTH     (TW),
      .CPL_SIZE          (32),
      .STATUS_FIFO_DEPTH (4)
   ) dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .s_axis_req_sel          (s_axis_req_sel),
      .s_axis_req_queue        (s_axis_req_queue),
      .s_axis_req_tag          (s_axis_req_tag),
      .s_axis_req_data         (s_axis_req_data),
      .s_axis_req_valid        (s_axis_req_valid),
      .s_axis_req_ready        (s_axis_req_ready),
      .m_axis_req_queue        (m_axis_req_queue),
      .m_axis_req_tag          (m_axis_req_tag),
      .m_axis_req_data         (m_axis_req_data),
      .m_axis_req_valid        (m_axis_req_valid),
      .m_axis_req_ready        (m_axis_req_ready),
      .s_axis_req_status_tag   (s_axis_req_status_tag),
      .s_axis_req_status_full  (s_axis_req_status_full),
      .s_axis_req_status_error (s_axis_req_status_error),
      .s_axis_req_status_valid (s_axis_req_status_valid),
      .m_axis_req_status_tag   (m_axis_req_status_tag),
      .m_axis_req_status_full  (m_axis_req_status_full),
      .m_axis_req_status_error (m_axis_req_status_error),
      .m_axis_req_status_valid (m_axis_req_status_valid),
      .status_unexpected       (status_unexpected)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic status_in(input int port, input logic [TW-1:0] tag);
      s_axis_req_status_valid[port]        = 1'b1;
      s_axis_req_status_tag[port*TW +: TW] = tag;
   endtask

   task automatic status_clear();
      s_axis_req_status_valid = '0;
      s_axis_req_status_tag   = '0;
   endtask

   // Every status pulse must match the next expected record, in order.
   always @(negedge clk) begin
      if (m_axis_req_status_valid) begin
         mon_got = {m_axis_req_status_tag, m_axis_req_status_full, m_axis_req_status_error};
         if (exp_q.size() == 0) chk("status_pending", 1'(exp_q.size() > 0), 1'b1);
         else chk("status_rec", mon_got, exp_q.pop_front());
      end
   end

   initial begin
      int  n_acc;
      logic acc;
      data1 = {8{32'h1234_5678}};
      s_axis_req_sel = '0; s_axis_req_queue = '0; s_axis_req_tag = '0; s_axis_req_data = '0;
      s_axis_req_valid = 1'b1; m_axis_req_ready = 2'b11;
      s_axis_req_status_full = '0; s_axis_req_status_error = '0; status_clear();

      // Reset state
      #1 rst_n = 1'b0;
      #2;
      chk("rst_ready", s_axis_req_ready, 0);
      chk("rst_mvalid", m_axis_req_valid, 0);
      chk("rst_svalid", m_axis_req_status_valid, 0);
      chk("rst_stag", m_axis_req_status_tag, 0);
      chk("rst_mqueue", m_axis_req_queue, 0);
      step(); step();
      rst_n = 1'b1; s_axis_req_valid = 1'b0;
      #1;

      // Single request to port 1 and its status
      s_axis_req_sel = 2'd1; s_axis_req_queue = 13'h0A5; s_axis_req_tag = 7'h12;
      s_axis_req_data = data1; s_axis_req_valid = 1'b1;
      #1 chk("t1_ready", s_axis_req_ready, 1);
      step(); s_axis_req_valid = 1'b0;
      chk("t1_mvalid", m_axis_req_valid, 2'b10);
      chk("t1_queue", m_axis_req_queue[2*QW-1:QW], 13'h0A5);
      chk("t1_tag", m_axis_req_tag[2*TW-1:TW], 7'h12);
      chk("t1_data", m_axis_req_data[2*DW-1:DW], data1);
      status_in(1, 7'h12); exp_q.push_back('{tag: 7'h12, full: 1'b0, error: 1'b0});
      step(); status_clear();
      chk("t1_lat1", m_axis_req_status_valid, 0);
      chk("t1_drain", m_axis_req_valid, 0);
      step(); chk("t1_lat2", m_axis_req_status_valid, 1);
      step(); chk("t1_pulse_end", m_axis_req_status_valid, 0);

      // Invalid select
      s_axis_req_sel = 2'd3; s_axis_req_tag = 7'h33; s_axis_req_valid = 1'b1;
      #1 chk("inv_ready", s_axis_req_ready, 1);
      exp_q.push_back('{tag: 7'h33, full: 1'b0, error: 1'b1});
      step(); s_axis_req_valid = 1'b0;
      chk("inv_fwd", m_axis_req_valid, 0);
      step(); chk("inv_pulse", m_axis_req_status_valid, 1);
      chk("inv_err", m_axis_req_status_error, 1);
      step();

      // Status with nothing outstanding
      chk("unexp_pre", status_unexpected, 0);
      status_in(1, 7'h77);
      step(); status_clear();
      chk("unexp_set", status_unexpected, 1);
      step(); step(); chk("unexp_nopulse", m_axis_req_status_valid, 0);

      // Backpressure and outstanding limit on port 0
      m_axis_req_ready = 2'b10;
      s_axis_req_sel = 2'd0; s_axis_req_queue = 13'h100; s_axis_req_tag = 7'h40;
      s_axis_req_valid = 1'b1;
      #1 chk("bp_first", s_axis_req_ready, 1);
      step(); chk("bp_rdy0", s_axis_req_ready, 0);
      s_axis_req_tag = 7'h41;
      step(); chk("bp_hold", s_axis_req_ready, 0);
      chk("bp_mvalid", m_axis_req_valid, 2'b01);
      chk("bp_mtag", m_axis_req_tag[TW-1:0], 7'h40);
      m_axis_req_ready = 2'b11;
      n_acc = 1;
      for (int i = 0; i < 6; i++) begin
         #1 acc = s_axis_req_ready;
         step();
         if (acc) begin
            n_acc++;
            s_axis_req_tag = s_axis_req_tag + 7'd1;
         end
      end
      #1 chk("bp_count", n_acc, 4);
      chk("bp_stall", s_axis_req_ready, 0);
      status_in(0, 7'h40); exp_q.push_back('{tag: 7'h40, full: 1'b0, error: 1'b0});
      step(); status_clear();
      #1 chk("bp_still", s_axis_req_ready, 0);
      step(); chk("bp_resume", s_axis_req_ready, 1);
      chk("bp_fifth_tag", s_axis_req_tag, 7'h44);
      step(); s_axis_req_valid = 1'b0;
      for (int t = 'h41; t <= 'h44; t++) begin
         status_in(0, 7'(t)); exp_q.push_back('{tag: 7'(t), full: 1'b0, error: 1'b0});
         step();
      end
      status_clear();
      repeat (4) step();

      // Simultaneous statuses; last grant was port 0, so port 1 wins first
      s_axis_req_sel = 2'd0; s_axis_req_tag = 7'h01; s_axis_req_valid = 1'b1;
      step(); s_axis_req_sel = 2'd1; s_axis_req_tag = 7'h02;
      step(); s_axis_req_valid = 1'b0;
      status_in(0, 7'h01); status_in(1, 7'h02);
      exp_q.push_back('{tag: 7'h02, full: 1'b0, error: 1'b0});
      exp_q.push_back('{tag: 7'h01, full: 1'b0, error: 1'b0});
      step(); status_clear();
      step(); chk("rr_first", m_axis_req_status_valid, 1);
      chk("rr_first_tag", m_axis_req_status_tag, 7'h02);
      step(); chk("rr_second", m_axis_req_status_valid, 1);
      chk("rr_second_tag", m_axis_req_status_tag, 7'h01);
      step(); chk("rr_done", m_axis_req_status_valid, 0);

      // Back-to-back statuses on port 0 interleaved with requests (FIFO wraps)
      for (int i = 0; i < 20; i++) begin
         s_axis_req_sel = 2'd0; s_axis_req_tag = 7'('h50 + i); s_axis_req_valid = 1'b1;
         if (i > 0) begin
            status_in(0, 7'('h50 + i - 1));
            exp_q.push_back('{tag: 7'('h50 + i - 1), full: 1'b0, error: 1'b0});
         end
         #1 chk("b2b_ready", s_axis_req_ready, 1);
         step();
      end
      s_axis_req_valid = 1'b0;
      status_in(0, 7'h63); exp_q.push_back('{tag: 7'h63, full: 1'b0, error: 1'b0});
      step(); status_clear();
      repeat (6) step();
      chk("b2b_drained", exp_q.size(), 0);

      // Reset mid-operation with two outstanding on port 0
      s_axis_req_sel = 2'd0; s_axis_req_queue = 13'h1FF; s_axis_req_tag = 7'h60;
      s_axis_req_valid = 1'b1;
      step(); s_axis_req_tag = 7'h61;
      step(); m_axis_req_ready = 2'b10; s_axis_req_tag = 7'h62;
      status_in(0, 7'h60);
      step(); status_clear();
      rst_n = 1'b0;
      #1;
      chk("mrst_mvalid", m_axis_req_valid, 0);
      chk("mrst_ready", s_axis_req_ready, 0);
      chk("mrst_svalid", m_axis_req_status_valid, 0);
      chk("mrst_stag", m_axis_req_status_tag, 0);
      chk("mrst_mqueue", m_axis_req_queue, 0);
      chk("mrst_mtag", m_axis_req_tag, 0);
      chk("mrst_unexp", status_unexpected, 0);
      step(); step();
      rst_n = 1'b1; m_axis_req_ready = 2'b11;
      for (int i = 0; i < 4; i++) begin
         s_axis_req_tag = 7'('h70 + i);
         #1 chk("post_rst_ready", s_axis_req_ready, 1);
         step();
      end
      #1 chk("post_rst_limit", s_axis_req_ready, 0);
      s_axis_req_valid = 1'b0;
      repeat (4) step();
      chk("final_queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
